// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_CMP,
        S_PASS,
        S_FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Wide enough for both the 16-bit timeout and the 24-bit re-check period.
    localparam int unsigned TMR_W = 24;

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module sysid_check_timer
    import sysid_check_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the system-ID and build timestamp words
// and reports whether they match the expected build values.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h6E52299A,
    parameter logic [31:0] EXPECTED_TS    = 32'h4E0A4324,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned RECHECK_PERIOD = 0,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        clear,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [31:0] id_q,
    output logic [31:0] ts_q,
    output logic [3:0]  retry_cnt
);

    localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] RCK_LOAD    = TMR_W'(RECHECK_PERIOD);
    localparam logic [3:0]       MAX_RETRY_W = 4'(MAX_RETRY);

    state_t           state, state_n;
    logic             auto_go;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             cap_id, cap_ts, retry_inc, new_check;
    logic [1:0]       err_n;
    logic             in_rd, is_ts, got_data, accept;

    sysid_check_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        in_rd    = (state == S_RD_ID) || (state == S_RD_TS);
        is_ts    = (state == S_RD_TS) || (state == S_WT_TS);
        // Data is taken in WT_x, or in RD_x when accept and valid coincide.
        got_data = avm_readdatavalid && (!in_rd || !avm_waitrequest);
        accept   = in_rd && !avm_waitrequest;
    end

    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_val   = TMO_LOAD;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        retry_inc = 1'b0;
        new_check = 1'b0;
        err_n     = ERR_NONE;
        case (state)
            S_IDLE: begin
                if (start || auto_go) begin
                    state_n   = S_RD_ID;
                    tmr_load  = 1'b1;
                    new_check = 1'b1;
                end
            end
            S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
                // Data wins over a coincident timeout; timeout wins over accept.
                if (got_data) begin
                    if (is_ts) begin
                        cap_ts  = 1'b1;
                        state_n = S_CMP;
                    end else begin
                        cap_id   = 1'b1;
                        state_n  = S_RD_TS;
                        tmr_load = 1'b1;
                    end
                end else if (tmr_zero) begin
                    if (retry_cnt < MAX_RETRY_W) begin
                        state_n   = S_RD_ID;
                        tmr_load  = 1'b1;
                        retry_inc = 1'b1;
                    end else begin
                        state_n = S_FAIL;
                        err_n   = ERR_TIMEOUT;
                    end
                end else if (accept) begin
                    state_n = is_ts ? S_WT_TS : S_WT_ID;
                end
            end
            S_CMP: begin
                if (id_q != EXPECTED_ID) begin
                    state_n = S_FAIL;
                    err_n   = ERR_ID;
                end else if (ts_q != EXPECTED_TS) begin
                    state_n = S_FAIL;
                    err_n   = ERR_TS;
                end else begin
                    state_n  = S_PASS;
                    tmr_load = 1'b1;
                    tmr_val  = RCK_LOAD;
                end
            end
            S_PASS: begin
                if (clear) begin
                    state_n = S_IDLE;
                end else if (RECHECK_PERIOD != 0 && tmr_zero) begin
                    state_n   = S_RD_ID;
                    tmr_load  = 1'b1;
                    new_check = 1'b1;
                end
            end
            S_FAIL: begin
                if (clear) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            auto_go     <= AUTO_START;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            err_code    <= ERR_NONE;
            id_q        <= '0;
            ts_q        <= '0;
            retry_cnt   <= '0;
        end else begin
            state       <= state_n;
            auto_go     <= 1'b0;
            avm_read    <= (state_n == S_RD_ID) || (state_n == S_RD_TS);
            avm_address <= (state_n == S_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy        <= state_n inside {S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_CMP};
            if (cap_id) begin
                id_q <= avm_readdata;
            end
            if (cap_ts) begin
                ts_q <= avm_readdata;
            end
            if (new_check) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            // pass stays up through a re-check until its result replaces it.
            if (state == S_CMP && state_n == S_PASS) begin
                pass     <= 1'b1;
                fail     <= 1'b0;
                err_code <= ERR_NONE;
            end else if (state != S_FAIL && state_n == S_FAIL) begin
                pass     <= 1'b0;
                fail     <= 1'b1;
                err_code <= err_n;
            end else if (state_n == S_IDLE) begin
                pass     <= 1'b0;
                fail     <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Randomised scoreboard bench for sysid_check_ctrl with a behavioural Avalon slave.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'h6E52299A;
    localparam logic [31:0] EXP_TS = 32'h4E0A4324;
    localparam int TMO  = 8;
    localparam int MAXR = 2;
    localparam int RCK  = 100;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic [1:0]  err;
        logic [31:0] id;
        logic [31:0] ts;
        logic [3:0]  retry;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, start, clear;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, pass, fail;
    logic [1:0]  err_code;
    logic [31:0] id_q, ts_q;
    logic [3:0]  retry_cnt;

    always #5 clk = ~clk;

    sysid_check_ctrl #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MAXR),
        .RECHECK_PERIOD (RCK),
        .AUTO_START     (1'b1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .clear             (clear),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .pass              (pass),
        .fail              (fail),
        .err_code          (err_code),
        .id_q              (id_q),
        .ts_q              (ts_q),
        .retry_cnt         (retry_cnt)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    exp_t q[$];
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    // Slave configuration.
    int          s_ws = 0;
    int          s_lat = 1;
    logic [31:0] s_id = EXP_ID;
    logic [31:0] s_ts = EXP_TS;
    bit          s_nv_id = 1'b0;
    bit          s_nv_ts = 1'b0;
    int          id_reads = 0;
    bit          id_delivered = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: result of one complete check given what the slave returns.
    task automatic push_expect(input logic [31:0] idv, input logic [31:0] tsv,
                               input bit nv_id, input bit nv_ts);
        exp_t e;
        e.pass  = 1'b0;
        e.fail  = 1'b1;
        e.retry = 4'd0;
        e.err   = 2'd0;
        if (nv_id) begin
            e.err   = 2'd3;
            e.retry = 4'(MAXR);
        end else begin
            m_id = idv;
            if (nv_ts) begin
                e.err   = 2'd3;
                e.retry = 4'(MAXR);
            end else begin
                m_ts = tsv;
                if (idv != EXP_ID) e.err = 2'd1;
                else if (tsv != EXP_TS) e.err = 2'd2;
                else begin
                    e.pass = 1'b1;
                    e.fail = 1'b0;
                end
            end
        end
        e.id = m_id;
        e.ts = m_ts;
        q.push_back(e);
    endtask

    task automatic serve();
        logic        a;
        logic [31:0] w;
        bit          nv;
        a = avm_address;
        if (a == 1'b0) begin
            id_reads++;
            id_delivered = 1'b0;
            w  = s_id;
            nv = s_nv_id;
        end else begin
            check("addr_order", 32'(id_delivered), 32'd1);
            id_delivered = 1'b0;
            w  = s_ts;
            nv = s_nv_ts;
        end
        for (int i = 0; i < s_ws; i++) begin
            avm_waitrequest = 1'b1;
            @(negedge clk);
            check("hold_read", 32'(avm_read), 32'd1);
            check("hold_addr", 32'(avm_address), 32'(a));
        end
        avm_waitrequest = 1'b0;
        if (!nv && s_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = w;
        end
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        if (!nv && s_lat > 0) begin
            repeat (s_lat - 1) @(negedge clk);
            avm_readdatavalid = 1'b1;
            avm_readdata      = w;
            @(negedge clk);
            avm_readdatavalid = 1'b0;
        end
        if (!nv && a == 1'b0) id_delivered = 1'b1;
    endtask

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        @(negedge clk);
        forever begin
            if (avm_read && reset_n) serve();
            else @(negedge clk);
        end
    end

    // Monitor: a completed check is marked by busy falling outside reset.
    logic bp = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bp && !busy && reset_n) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got pass=%0b fail=%0b err=%0d want no result",
                             pass, fail, err_code);
                end else begin
                    e = q.pop_front();
                    check("res_pass", 32'(pass), 32'(e.pass));
                    check("res_fail", 32'(fail), 32'(e.fail));
                    check("res_err", 32'(err_code), 32'(e.err));
                    check("res_id", id_q, e.id);
                    check("res_ts", ts_q, e.ts);
                    check("res_retry", 32'(retry_cnt), 32'(e.retry));
                end
                done_cnt++;
            end
            bp = busy;
        end
    end

    task automatic wait_done(input int prev, input string name);
        int n;
        n = 0;
        while (done_cnt == prev && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == prev) begin
            total++;
            bad++;
            $display("FAIL %s: got no result after 300 cycles want a result", name);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic set_slave(input int ws, input int lat, input logic [31:0] idv,
                             input logic [31:0] tsv, input bit nv_id, input bit nv_ts);
        s_ws = ws; s_lat = lat; s_id = idv; s_ts = tsv; s_nv_id = nv_id; s_nv_ts = nv_ts;
    endtask

    task automatic run_check(input int ws, input int lat, input logic [31:0] idv,
                             input logic [31:0] tsv, input bit nv_id, input bit nv_ts,
                             input bit mid_clear, input string name);
        int prev;
        set_slave(ws, lat, idv, tsv, nv_id, nv_ts);
        push_expect(idv, tsv, nv_id, nv_ts);
        prev = done_cnt;
        pulse_start();
        if (mid_clear) pulse_clear();
        wait_done(prev, name);
        pulse_clear();
    endtask

    initial begin
        int prev, cyc, n;
        reset_n = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        set_slave(0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_id", id_q, 32'd0);
        check("rst_ts", ts_q, 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);

        // Auto-start after reset release.
        push_expect(EXP_ID, EXP_TS, 1'b0, 1'b0);
        prev = done_cnt;
        reset_n = 1'b1;
        wait_done(prev, "autostart");
        pulse_clear();

        // Zero-wait slave: result within 6 cycles of start.
        push_expect(EXP_ID, EXP_TS, 1'b0, 1'b0);
        prev = done_cnt;
        pulse_start();
        cyc = 1;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc > 6) begin
            bad++;
            $display("FAIL start_to_done: got %0d cycles want <= 6", cyc);
        end
        wait_done(prev, "latency");
        pulse_clear();

        // ID mismatch, sticky fail, start ignored, clear.
        set_slave(0, 1, 32'h6E52299B, EXP_TS, 1'b0, 1'b0);
        push_expect(32'h6E52299B, EXP_TS, 1'b0, 1'b0);
        prev = done_cnt;
        pulse_start();
        wait_done(prev, "id_mismatch");
        pulse_start();
        repeat (3) @(negedge clk);
        check("fail_start_busy", 32'(busy), 32'd0);
        check("fail_sticky", 32'(fail), 32'd1);
        check("fail_err", 32'(err_code), 32'd1);
        check("fail_id", id_q, 32'h6E52299B);
        pulse_clear();
        check("clr_pass", 32'(pass), 32'd0);
        check("clr_fail", 32'(fail), 32'd0);
        check("clr_err", 32'(err_code), 32'd0);

        // Long waitrequest, then all-timeout with retries.
        run_check(5, 1, EXP_ID, EXP_TS, 1'b0, 1'b0, 1'b0, "waitreq");
        id_reads = 0;
        run_check(0, 1, EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, "timeout");
        check("attempts", 32'(id_reads), 32'd3);

        for (int it = 0; it < 24; it++) begin
            int          ws, lat, r;
            logic [31:0] idv, tsv;
            ws  = $urandom_range(0, 3);
            lat = $urandom_range(0, 3);
            r   = $urandom_range(0, 9);
            idv = (r == 0) ? $urandom : EXP_ID;
            tsv = (r == 1) ? $urandom : EXP_TS;
            run_check(ws, lat, idv, tsv, r == 2, r == 3, $urandom_range(0, 3) == 0, "random");
        end

        // Periodic re-check with the timestamp changed after the first pass.
        set_slave(1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
        push_expect(EXP_ID, EXP_TS, 1'b0, 1'b0);
        prev = done_cnt;
        pulse_start();
        wait_done(prev, "recheck_first");
        s_ts = 32'd0;
        push_expect(EXP_ID, 32'd0, 1'b0, 1'b0);
        prev = done_cnt;
        n = 0;
        while (!busy && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("recheck_busy", 32'(busy), 32'd1);
        check("recheck_pass_held", 32'(pass), 32'd1);
        wait_done(prev, "recheck");
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("clrstart_busy", 32'(busy), 32'd0);
        check("clrstart_fail", 32'(fail), 32'd0);
        check("clrstart_pass", 32'(pass), 32'd0);

        // Reset during WT_TS, late readdatavalid after release.
        set_slave(0, 1, EXP_ID, EXP_TS, 1'b0, 1'b1);
        pulse_start();
        n = 0;
        while (!(avm_read && avm_address) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd_ts", 32'(avm_read && avm_address), 32'd1);
        while (avm_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_ctrl", 32'({busy, pass, fail, err_code, retry_cnt, avm_read}), 32'd0);
        check("rstmid_id", id_q, 32'd0);
        s_nv_ts = 1'b0;
        m_id = '0;
        m_ts = '0;
        push_expect(EXP_ID, EXP_TS, 1'b0, 1'b0);
        prev = done_cnt;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h12345678;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        check("late_id", id_q, 32'd0);
        check("late_ts", ts_q, 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done(prev, "after_reset");
        pulse_clear();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
